// File: rtl/mitchell_div8_pipe_pkg.sv
// Shared widths and types for the Mitchell logarithmic divider: operand, log-word,
// fraction and quotient widths, plus the flags carried alongside each pipe entry.
package mitchell_pkg;

  localparam int unsigned OPW   = 8;
  localparam int unsigned LOGW  = 11;
  localparam int unsigned FRACW = 7;
  localparam int unsigned QW    = 16;
  localparam int unsigned KW    = 3;

  typedef struct packed {
    logic [KW-1:0]    k;
    logic [FRACW-1:0] f;
  } log_word_t;

  // Special-case outcome decided in S1; dz takes precedence over zero.
  typedef struct packed {
    logic dz;
    logic zero;
  } spec_flags_t;

  function automatic spec_flags_t classify(input logic x_zero, input logic y_zero);
    spec_flags_t fl;
    fl.dz   = y_zero;
    fl.zero = x_zero & ~y_zero;
    return fl;
  endfunction

endpackage

// File: rtl/mitchell_div8_pipe_log8.sv
// Leading-one detect and mantissa normalisation for one 8-bit operand:
// log2(v) ~= k + f/128, with is_zero flagging v == 0.
module mitchell_log8
  import mitchell_pkg::*;
(
  input  logic [OPW-1:0]   v,
  output logic [KW-1:0]    k,
  output logic [FRACW-1:0] f,
  output logic             is_zero
);

  logic [OPW-1:0] norm;

  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < OPW; i++) begin
      if (v[i]) k = KW'(i);
    end
    norm    = v << (KW'(OPW - 1) - k);
    f       = norm[FRACW-1:0];
    is_zero = (v == '0);
  end

endmodule

// File: rtl/mitchell_div8_pipe.sv
// Three-stage elastic Mitchell divider: S1 log-encodes both operands, S2 subtracts
// in the log domain, S3 applies the anti-log shift and presents the Q8.8 quotient.
module mitchell_div8_pipe
  import mitchell_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [7:0]    x_i,
  input  logic [7:0]    y_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [15:0]   q_o,
  output logic          dz_o
);

  logic        v1, v2, v3;
  logic        rdy1, rdy2, rdy3;

  log_word_t   lx, ly;
  logic        x_zero, y_zero;

  log_word_t   s1_lx, s1_ly;
  spec_flags_t s1_fl;

  logic [LOGW-1:0] l_diff;
  logic [LOGW-1:0] s2_l;
  spec_flags_t     s2_fl;

  logic [3:0]      n;
  logic [OPW-1:0]  m;
  logic [QW-1:0]   m_ext;
  logic [QW-1:0]   q_shift;
  logic [QW-1:0]   q_next;

  mitchell_log8 u_log_x (
    .v       (x_i),
    .k       (lx.k),
    .f       (lx.f),
    .is_zero (x_zero)
  );

  mitchell_log8 u_log_y (
    .v       (y_i),
    .k       (ly.k),
    .f       (ly.f),
    .is_zero (y_zero)
  );

  // Ready ripples back from the consumer so a full pipe can push and pop together.
  always_comb begin
    rdy3       = ~v3 | out_ready_i;
    rdy2       = ~v2 | rdy3;
    rdy1       = ~v1 | rdy2;
    in_ready_o = rdy1;
  end

  assign l_diff = {1'b0, s1_lx} - {1'b0, s1_ly};

  // For n < 0, -n-1 equals the bitwise complement of the 4-bit two's-complement n.
  always_comb begin
    n     = s2_l[LOGW-1:FRACW];
    m     = {1'b1, s2_l[FRACW-1:0]};
    m_ext = {{(QW - OPW){1'b0}}, m};
    if (!n[3]) q_shift = m_ext << ({1'b0, n[2:0]} + 4'd1);
    else       q_shift = m_ext >> (~n[2:0]);
    if (s2_fl.dz)        q_next = '1;
    else if (s2_fl.zero) q_next = '0;
    else                 q_next = q_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1_lx <= '0;
      s1_ly <= '0;
      s1_fl <= '0;
      s2_l  <= '0;
      s2_fl <= '0;
      q_o   <= '0;
      dz_o  <= 1'b0;
    end else begin
      if (rdy1) begin
        v1 <= in_valid_i;
        if (in_valid_i) begin
          s1_lx <= lx;
          s1_ly <= ly;
          s1_fl <= classify(x_zero, y_zero);
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          s2_l  <= l_diff;
          s2_fl <= s1_fl;
        end
      end
      if (rdy3) begin
        v3 <= v2;
        if (v2) begin
          q_o  <= q_next;
          dz_o <= s2_fl.dz;
        end
      end
    end
  end

  assign out_valid_o = v3;

endmodule

// File: tb/tb_mitchell_div8_pipe.sv
// Scoreboard bench for mitchell_div8_pipe: expected results are queued at input
// transfer from an arithmetic reference model and popped by an output monitor.
module tb_mitchell_div8_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  x_i;
  logic [7:0]  y_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] q_o;
  logic        dz_o;

  always #5 clk_i = ~clk_i;

  mitchell_div8_pipe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .q_o         (q_o),
    .dz_o        (dz_o)
  );

  typedef struct {
    logic [15:0] q;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // log2 in 1/128 units: floor(log2 v)*128 + mantissa bits below the leading one.
  function automatic int log_fixed(input int v);
    int k = 0;
    while ((v >> (k + 1)) != 0) k++;
    return k * 128 + ((v << (7 - k)) % 128);
  endfunction

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int l, r, n, m;
    if (y == 0) begin
      e.q = 16'hFFFF; e.dz = 1'b1; return e;
    end
    e.dz = 1'b0;
    if (x == 0) begin
      e.q = 16'h0000; return e;
    end
    l = log_fixed(x) - log_fixed(y);
    r = ((l % 128) + 128) % 128;
    n = (l - r) / 128;
    m = 128 + r;
    if (n >= 0) e.q = 16'(m << (n + 1));
    else        e.q = 16'(m >> (-n - 1));
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got q=%0h with no pending result", q_o);
      end else begin
        mon_e = sb.pop_front();
        check("sb_q", int'(q_o), int'(mon_e.q));
        check("sb_dz", int'(dz_o), int'(mon_e.dz));
      end
    end
  end

  // Entered and left at #1 after a rising edge; in_valid_i stays high on return.
  task automatic send(input logic [7:0] x, input logic [7:0] y, output int waits);
    bit done = 0;
    waits = 0;
    in_valid_i = 1'b1;
    x_i = x;
    y_i = y;
    while (!done) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        sb.push_back(model(int'(x), int'(y)));
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk_i);
      #1;
      if (!done && waits > 60) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got no accept expected accept within 60 cycles");
        done = 1;
      end
    end
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic directed(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] eq, input logic edz);
    int w;
    logic [2:0] pat;
    send(x, y, w);
    idle();
    pat[0] = out_valid_o;
    @(posedge clk_i); #1;
    pat[1] = out_valid_o;
    @(posedge clk_i); #1;
    pat[2] = out_valid_o;
    check("latency_valid", int'(pat), 3'b100);
    check("dir_q", int'(q_o), int'(eq));
    check("dir_dz", int'(dz_o), int'(edz));
    @(posedge clk_i); #1;
  endtask

  initial begin
    int w, stalls, bubbles, stale;
    logic [16:0] prev;
    bit have;

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    x_i = '0;
    y_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_q", int'(q_o), 0);
    check("rst_dz", int'(dz_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_in_ready", int'(in_ready_o), 1);

    directed(8'd200, 8'd10,  16'h1500, 1'b0);
    directed(8'd255, 8'd1,   16'hFF00, 1'b0);
    directed(8'd1,   8'd255, 16'h0001, 1'b0);
    directed(8'd10,  8'd200, 16'h000D, 1'b0);
    directed(8'd37,  8'd37,  16'h0100, 1'b0);
    directed(8'd0,   8'd5,   16'h0000, 1'b0);
    directed(8'd9,   8'd0,   16'hFFFF, 1'b1);
    directed(8'd0,   8'd0,   16'hFFFF, 1'b1);

    // Back-pressure: consumer stalls 5 cycles while 6 operands are offered.
    out_ready_i = 1'b0;
    have = 0;
    prev = '0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), w);
          if (i == 2) check("bp_in_ready_full", int'(in_ready_o), 0);
        end
        idle();
      end
      begin
        repeat (5) begin
          @(negedge clk_i);
          if (out_valid_o && !out_ready_i) begin
            if (have) check("bp_hold", int'({dz_o, q_o}), int'(prev));
            prev = {dz_o, q_o};
            have = 1;
          end
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Full-rate random stream.
    stalls = 0;
    bubbles = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] rx, ry;
      if (i >= 3 && !out_valid_o) bubbles++;
      rx = 8'($urandom_range(0, 255));
      ry = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      send(rx, ry, w);
      stalls += w;
    end
    idle();
    drain();
    check("stream_stalls", stalls, 0);
    check("stream_bubbles", bubbles, 0);

    // Reset with three results in flight.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), w);
    idle();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("midrst_out_valid", int'(out_valid_o), 0);
    check("midrst_q", int'(q_o), 0);
    check("midrst_in_ready", int'(in_ready_o), 1);
    sb.delete();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    stale = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (out_valid_o) stale++;
    end
    check("midrst_stale", stale, 0);
    directed(8'd100, 8'd7, 16'h0E80, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
